// File: rtl/lsu_mem_bridge.sv
// LSU-to-SRAM bridge: write-priority arbitration with an in-order read queue.
// Optional access/stall counters are built when LSU_BRIDGE_STATS_EN is defined.
module lsu_mem_bridge #(
  parameter int A_W   = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [A_W:0]          R_request,
  input  logic [A_W+DW+2:0]     W_request,
  output logic [DW:0]           CBG_to_LSU_bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [A_W-1:0]        mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic [DW/8-1:0]       mem_wmask,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  rq_full,
  output logic                  rq_overflow
`ifdef LSU_BRIDGE_STATS_EN
  ,
  output logic [31:0]           stat_rd,
  output logic [31:0]           stat_wr,
  output logic [31:0]           stat_stall
`endif
);

  localparam int MW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           ren;
  logic [A_W-1:0] raddr;
  logic [1:0]     w_sel;
  logic           wen;
  logic [A_W-1:0] waddr;
  logic [DW-1:0]  wdata;

  assign ren   = R_request[A_W];
  assign raddr = R_request[A_W-1:0];
  assign w_sel = W_request[A_W+DW+2 -: 2];
  assign wen   = W_request[A_W+DW];
  assign waddr = W_request[A_W+DW-1 -: A_W];
  assign wdata = W_request[DW-1:0];

  logic [A_W-1:0] queue [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count, count_next;
  logic           rd_pending;

  logic [MW-1:0]  wmask_dec;
  logic           wr_go, pop, direct, push, push_ok, drop, rd_go, empty, full;

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    wmask_dec = '0;
    case (w_sel)
      2'b00:   wmask_dec = '1;
      2'b01:   wmask_dec = {MW{1'b1}} >> (MW - MW / 2);
      2'b10:   wmask_dec = MW'(1);
      default: wmask_dec = '0;
    endcase
  end

  // Reset gates issue so the SRAM sees no access while rst is held.
  always_comb begin
    empty      = (count == '0);
    full       = (count == CW'(DEPTH));
    wr_go      = !rst && wen && (w_sel != 2'b11);
    pop        = !rst && !wr_go && !empty;
    direct     = !rst && !wr_go && empty && ren;
    push       = !rst && ren && !direct;
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    rd_go      = pop || direct;
    count_next = count + CW'(push_ok) - CW'(pop);

    mem_en    = wr_go || rd_go;
    mem_we    = wr_go;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (wr_go) begin
      mem_addr  = waddr;
      mem_wdata = wdata;
      mem_wmask = wmask_dec;
    end else if (pop) begin
      mem_addr = queue[head];
    end else if (direct) begin
      mem_addr = raddr;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      rq_full        <= 1'b0;
      rq_overflow    <= 1'b0;
      rd_pending     <= 1'b0;
      CBG_to_LSU_bus <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      count       <= count_next;
      rq_full     <= (count_next == CW'(DEPTH));
      if (drop) rq_overflow <= 1'b1;
      rd_pending  <= rd_go;
      if (rd_pending) CBG_to_LSU_bus <= {1'b1, mem_rdata};
      else            CBG_to_LSU_bus[DW] <= 1'b0;
    end
  end

  // NOTE: queue storage is not reset; the pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) queue[tail] <= raddr;
  end

`ifdef LSU_BRIDGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      if (rd_go && stat_rd != 32'hFFFF_FFFF)             stat_rd    <= stat_rd + 32'd1;
      if (wr_go && stat_wr != 32'hFFFF_FFFF)             stat_wr    <= stat_wr + 32'd1;
      if (!empty && !pop && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with an SRAM model and a read-data scoreboard.
// Build with LSU_BRIDGE_STATS_EN defined to also check the statistics counters.
module tb_lsu_mem_bridge;
  localparam int A_W   = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [A_W:0]         R_request;
  logic [A_W+DW+2:0]    W_request;
  logic [DW:0]          CBG_to_LSU_bus;
  logic                 mem_en, mem_we;
  logic [A_W-1:0]       mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW/8-1:0]      mem_wmask;
  logic [DW-1:0]        mem_rdata;
  logic                 rq_full, rq_overflow;
`ifdef LSU_BRIDGE_STATS_EN
  logic [31:0]          stat_rd, stat_wr, stat_stall;
`endif

  lsu_mem_bridge #(.A_W(A_W), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .R_request(R_request), .W_request(W_request),
    .CBG_to_LSU_bus(CBG_to_LSU_bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .rq_full(rq_full), .rq_overflow(rq_overflow)
`ifdef LSU_BRIDGE_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten word a reads as 32'hCAFE0000 | a.
  logic [DW-1:0] mem_arr [1024];
  bit            written [1024];
  always @(posedge clk) begin
    logic [DW-1:0] cur;
    cur = written[mem_addr] ? mem_arr[mem_addr] : (32'hCAFE_0000 | 32'(mem_addr));
    if (mem_en && mem_we) begin
      for (int b = 0; b < DW / 8; b++)
        if (mem_wmask[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
      mem_arr[mem_addr] <= cur;
      written[mem_addr] <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= cur;
    end
  end

  int            compared   = 0;
  int            mismatched = 0;
  int            n_valid    = 0;
  int            base;
  logic [DW-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (CBG_to_LSU_bus[DW] === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("valid_with_empty_scoreboard", {63'd0, CBG_to_LSU_bus[DW]}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", 64'(CBG_to_LSU_bus[DW-1:0]), 64'(e));
      end
    end
  endtask

  function automatic logic [A_W+DW+2:0] wreq(input logic [1:0] sel, input logic en,
                                             input logic [A_W-1:0] a, input logic [DW-1:0] d);
    return {sel, en, a, d};
  endfunction

  function automatic logic [A_W:0] rreq(input logic en, input logic [A_W-1:0] a);
    return {en, a};
  endfunction

  task automatic idle();
    R_request = '0;
    W_request = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", 64'(CBG_to_LSU_bus), 64'd0);
    check("reset_mem_en", 64'(mem_en), 64'd0);
    check("reset_rq_full", 64'(rq_full), 64'd0);
    check("reset_overflow", 64'(rq_overflow), 64'd0);
`ifdef LSU_BRIDGE_STATS_EN
    check("reset_stats", {stat_rd, stat_wr | stat_stall}, 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Direct read: issue in request cycle, data two edges later.
    R_request = rreq(1'b1, 10'd5);
    #1;
    check("t1_en", 64'(mem_en), 64'd1);
    check("t1_we", 64'(mem_we), 64'd0);
    check("t1_addr", 64'(mem_addr), 64'd5);
    sb.push_back(32'hCAFE_0005);
    base = n_valid;
    tick(); idle();
    check("t1_valid_edge1", 64'(CBG_to_LSU_bus[DW]), 64'd0);
    tick();
    check("t1_pulses", 64'(n_valid - base), 64'd1);
    tick();
    check("t1_pulse_single", 64'(CBG_to_LSU_bus[DW]), 64'd0);
    check("t1_rdata_hold", 64'(CBG_to_LSU_bus[DW-1:0]), 64'hCAFE_0005);

    // Write then read same address.
    W_request = wreq(2'b00, 1'b1, 10'd7, 32'h1234_5678);
    #1;
    check("t2_wmask", 64'(mem_wmask), 64'hF);
    check("t2_we", 64'({mem_en, mem_we}), 64'b11);
    tick(); idle();
    R_request = rreq(1'b1, 10'd7);
    sb.push_back(32'h1234_5678);
    base = n_valid;
    tick(); idle();
    tick();
    check("t2_pulses", 64'(n_valid - base), 64'd1);

    // Collision: write first, read next cycle, valid 3 edges after request.
    R_request = rreq(1'b1, 10'd3);
    W_request = wreq(2'b00, 1'b1, 10'd9, 32'hDEAD_BEEF);
    sb.push_back(32'hCAFE_0003);
    #1;
    check("t3_write_first", 64'({mem_we, mem_addr}), 64'({1'b1, 10'd9}));
    base = n_valid;
    tick(); idle();
    #1;
    check("t3_queued_read", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, 10'd3}));
    tick();
    check("t3_valid_edge2", 64'(CBG_to_LSU_bus[DW]), 64'd0);
    tick();
    check("t3_valid_edge3", 64'(n_valid - base), 64'd1);

    // Overflow: six write cycles each with a read; only four fit.
    for (int i = 0; i < 6; i++) begin
      W_request = wreq(2'b00, 1'b1, 10'(100 + i), 32'(i));
      R_request = rreq(1'b1, 10'(30 + i));
      if (i < DEPTH) sb.push_back(32'hCAFE_0000 | 32'(30 + i));
      tick();
      check($sformatf("t4_full_%0d", i), 64'(rq_full), (i >= DEPTH - 1) ? 64'd1 : 64'd0);
      check($sformatf("t4_ovf_%0d", i), 64'(rq_overflow), (i >= DEPTH) ? 64'd1 : 64'd0);
    end
    idle();
    base = n_valid;
    tick();
    check("t4_full_after_pop", 64'(rq_full), 64'd0);
    repeat (7) tick();
    check("t4_pulses", 64'(n_valid - base), 64'd4);
    check("t4_ovf_sticky", 64'(rq_overflow), 64'd1);

    // Write masks and the reserved encoding.
    W_request = wreq(2'b01, 1'b1, 10'd20, 32'hAAAA_BBBB);
    #1;
    check("t5_mask_half", 64'(mem_wmask), 64'h3);
    tick();
    W_request = wreq(2'b10, 1'b1, 10'd21, 32'h1122_3344);
    #1;
    check("t5_mask_byte", 64'(mem_wmask), 64'h1);
    tick();
    W_request = wreq(2'b11, 1'b1, 10'd22, 32'hFFFF_FFFF);
    #1;
    check("t5_reserved_no_en", 64'(mem_en), 64'd0);
    tick(); idle();
    R_request = rreq(1'b1, 10'd20); sb.push_back(32'hCAFE_BBBB); tick();
    R_request = rreq(1'b1, 10'd21); sb.push_back(32'hCAFE_0044); tick();
    R_request = rreq(1'b1, 10'd22); sb.push_back(32'hCAFE_0016); tick();
    idle();
    repeat (3) tick();
    check("t5_drained", 64'(sb.size()), 64'd0);
`ifdef LSU_BRIDGE_STATS_EN
    check("stat_rd", 64'(stat_rd), 64'd10);
    check("stat_wr", 64'(stat_wr), 64'd10);
    check("stat_stall", 64'(stat_stall), 64'd5);
`endif

    // Reset with two reads queued: all discarded.
    W_request = wreq(2'b00, 1'b1, 10'd200, 32'h1);
    R_request = rreq(1'b1, 10'd40);
    tick();
    W_request = wreq(2'b00, 1'b1, 10'd201, 32'h2);
    R_request = rreq(1'b1, 10'd41);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("t6_ovf_cleared", 64'(rq_overflow), 64'd0);
    check("t6_bus_cleared", 64'(CBG_to_LSU_bus), 64'd0);
`ifdef LSU_BRIDGE_STATS_EN
    check("t6_stats_cleared", {stat_rd, stat_wr | stat_stall}, 64'd0);
`endif
    base = n_valid;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("t6_no_valid", 64'(n_valid - base), 64'd0);
    check("t6_idle_mem", 64'(mem_en), 64'd0);
    check("t6_rq_full", 64'(rq_full), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
